ula_sequencer: RTL and testbench
================================

# ula_sequencer

Multi-cycle command sequencer that drives the combinational ALU (`ULA`) as its initiator. Accepts register-to-register arithmetic commands over a valid/ready handshake, reads a small register file, presents opcode and operands to the ALU, captures result and flags, writes back, and returns a response. Sits between the instruction decode path and the `ULA` instance, owning the architectural 8-bit register file and flag register.

## Interface
Parameters:
- `NREG`, 4: number of 8-bit registers; must be a power of two and at least 2.
- `AW`, $clog2(NREG): register address width. Derived; do not override.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_opcode` in 8: 0x01 ADD, 0x02 SUB, 0x03 MUL, 0x04 DIV, 0x05 MOD, 0x10 LOADI; all others invalid.
- `cmd_src_a` in AW: source register for operand1.
- `cmd_src_b` in AW: source register for operand2.
- `cmd_dst` in AW: destination register.
- `cmd_imm` in 8: immediate, used only by LOADI.
- `alu_opcode` out 8: to ULA opcode.
- `alu_operand1` out 8: to ULA operand1.
- `alu_operand2` out 8: to ULA operand2.
- `alu_result` in 8: from ULA result.
- `alu_flags` in 8: from ULA flags.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_data` out 8: value written, or 0 on error.
- `rsp_flags` out 8: ALU flags of this command, or 0 for LOADI/error.
- `rsp_err` out 1: invalid opcode or DIV/MOD by zero.
- `flags_q` out 8: architectural flag register.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch opcode, dst, imm, and operands read from the register file (`reg[src_a]`, `reg[src_b]`) into operand registers; go EXEC.
- EXEC: `alu_opcode`/`alu_operand*` driven from latched registers. At the closing edge:
  - ALU op (0x01–0x05), valid divisor: `reg[dst]` ← `alu_result`; `flags_q` ← `alu_flags`; rsp_data/flags ← result/flags; `rsp_err`=0.
  - DIV or MOD with operand2 = 0: no writeback, `flags_q` unchanged, `rsp_err`=1, data/flags 0.
  - LOADI: `reg[dst]` ← imm; `flags_q` unchanged; rsp_data=imm, rsp_flags=0, `rsp_err`=0.
  - Invalid opcode: no writeback, `rsp_err`=1, data/flags 0.
  - Go RESP.
- RESP: `rsp_valid`=1, response outputs stable until `rsp_valid && rsp_ready`; then IDLE.
- Outside EXEC, `alu_opcode`=0 (ULA outputs 0); operands 0.
- `dst` equal to a source is legal; sources use pre-write values.
- Register writes occur only at the EXEC→RESP edge, so the next command always reads committed values.

## Timing
- Reset (async assert, sync release): state IDLE, all registers and `flags_q` 0, `rsp_valid`/`rsp_err`/`busy` 0, `rsp_data`/`rsp_flags` 0, `alu_*` 0, `cmd_ready` 1.
- Accept edge T → EXEC during cycle T..T+1 → writeback and `rsp_valid`=1 after edge T+1. Latency: 2 edges from accept to response.
- With `rsp_ready` held high, throughput is one command per 3 cycles. `cmd_ready` is 0 in EXEC and RESP; there is no overlap.
- `rsp_ready` low stalls in RESP indefinitely; no output changes.
- Reset asserted in EXEC or RESP aborts: no writeback and the response is dropped.

## Structure
- Shared package `ula_pkg`: opcode localparams (OP_ADD…OP_MOD, OP_LOADI), state enum, data width constant 8.
- One sub-module, `ula_regfile`: NREG×8 storage, two combinational read ports, one synchronous write port, async reset to 0.
- `ULA` is instantiated by the parent, not inside this block.

## Test plan
Bench uses a behavioural ULA model.
- LOADI r0←7, LOADI r1←3 → rsp_data 0x07, then 0x03; rsp_err 0; flags_q 0.
- ADD r2←r0+r1 → rsp_data 0x0A, rsp_flags[0]=0, flags_q updated; then SUB r3←r1−r1 → rsp_data 0, rsp_flags[0]=1.
- DIV r0←r0/r3 with r3=0 → rsp_err 1, rsp_data 0, r0 still 7, flags_q unchanged; opcode 0x07 → rsp_err 1, no writeback.
- Hold rsp_ready low for 5 cycles after the ADD response → rsp_* stable, cmd_ready 0, busy 1; release → IDLE the next cycle.
- Assert rst during EXEC of MUL r0←r0*r1 → all outputs reset immediately, r0 reads 0 afterwards, no rsp_valid.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA command sequencer: data width, opcode
// encodings, sequencer state encoding and small opcode-decode helpers.
package ula_pkg;

   localparam int DW = 8;

   localparam logic [7:0] OP_NONE  = 8'h00;
   localparam logic [7:0] OP_ADD   = 8'h01;
   localparam logic [7:0] OP_SUB   = 8'h02;
   localparam logic [7:0] OP_MUL   = 8'h03;
   localparam logic [7:0] OP_DIV   = 8'h04;
   localparam logic [7:0] OP_MOD   = 8'h05;
   localparam logic [7:0] OP_LOADI = 8'h10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // True for the opcodes whose divisor must be non-zero.
   function automatic logic is_div_op(input logic [7:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/ula_regfile.sv
// Architectural register file: NREG x 8-bit, two combinational read ports,
// one synchronous write port, asynchronous reset to zero.
module ula_regfile import ula_pkg::*; #(
   parameter int NREG = 4,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic [DW-1:0] rd_data_a,
   output logic [DW-1:0] rd_data_b,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data
);

   logic [DW-1:0] regs [NREG];

   // Storage update: clear everything on reset, otherwise single-port write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= 8'h00;
         end
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = regs[rd_addr_a];
   assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/ula_sequencer.sv
// Command sequencer in front of the combinational ULA. Accepts one command
// at a time, reads operands from the register file, presents them to the
// ULA for one cycle, commits the result and returns a response.
module ula_sequencer import ula_pkg::*; #(
   parameter  int NREG = 4,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [7:0]    cmd_opcode,
   input  logic [AW-1:0] cmd_src_a,
   input  logic [AW-1:0] cmd_src_b,
   input  logic [AW-1:0] cmd_dst,
   input  logic [7:0]    cmd_imm,
   output logic [7:0]    alu_opcode,
   output logic [7:0]    alu_operand1,
   output logic [7:0]    alu_operand2,
   input  logic [7:0]    alu_result,
   input  logic [7:0]    alu_flags,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [7:0]    rsp_data,
   output logic [7:0]    rsp_flags,
   output logic          rsp_err,
   output logic [7:0]    flags_q,
   output logic          busy
);

   state_t        state;
   logic [AW-1:0] dst;
   logic [7:0]    imm;

   logic [7:0]    rd_data_a;
   logic [7:0]    rd_data_b;

   // Outcome of the command currently in EXEC.
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          res_err;
   logic          res_upd_flags;
   logic [7:0]    res_data;
   logic [7:0]    res_flags;

   ula_regfile #(
      .NREG (NREG),
      .AW   (AW)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (cmd_src_a),
      .rd_addr_b (cmd_src_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .wr_en     (wr_en),
      .wr_addr   (dst),
      .wr_data   (wr_data)
   );

   // Decode the latched opcode and the ULA outputs into writeback/response values.
   always_comb begin
      wr_en         = 1'b0;
      wr_data       = 8'h00;
      res_err       = 1'b0;
      res_upd_flags = 1'b0;
      res_data      = 8'h00;
      res_flags     = 8'h00;
      if (state == ST_EXEC) begin
         case (alu_opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
               if (is_div_op(alu_opcode) && (alu_operand2 == 8'h00)) begin
                  res_err = 1'b1;
               end else begin
                  wr_en         = 1'b1;
                  wr_data       = alu_result;
                  res_upd_flags = 1'b1;
                  res_data      = alu_result;
                  res_flags     = alu_flags;
               end
            end
            OP_LOADI: begin
               wr_en    = 1'b1;
               wr_data  = imm;
               res_data = imm;
            end
            default: begin
               res_err = 1'b1;
            end
         endcase
      end else begin
         wr_en = 1'b0;
      end
   end

   // Control FSM with all externally visible outputs held in registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         dst          <= '0;
         imm          <= 8'h00;
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         alu_opcode   <= OP_NONE;
         alu_operand1 <= 8'h00;
         alu_operand2 <= 8'h00;
         rsp_valid    <= 1'b0;
         rsp_data     <= 8'h00;
         rsp_flags    <= 8'h00;
         rsp_err      <= 1'b0;
         flags_q      <= 8'h00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  state        <= ST_EXEC;
                  dst          <= cmd_dst;
                  imm          <= cmd_imm;
                  alu_opcode   <= cmd_opcode;
                  alu_operand1 <= rd_data_a;
                  alu_operand2 <= rd_data_b;
                  cmd_ready    <= 1'b0;
                  busy         <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               state        <= ST_RESP;
               alu_opcode   <= OP_NONE;
               alu_operand1 <= 8'h00;
               alu_operand2 <= 8'h00;
               rsp_valid    <= 1'b1;
               rsp_data     <= res_data;
               rsp_flags    <= res_flags;
               rsp_err      <= res_err;
               if (res_upd_flags) begin
                  flags_q <= alu_flags;
               end else begin
                  flags_q <= flags_q;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_data  <= 8'h00;
                  rsp_flags <= 8'h00;
                  rsp_err   <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  state <= ST_RESP;
               end
            end
            default: begin
               state        <= ST_IDLE;
               cmd_ready    <= 1'b1;
               busy         <= 1'b0;
               alu_opcode   <= OP_NONE;
               alu_operand1 <= 8'h00;
               alu_operand2 <= 8'h00;
               rsp_valid    <= 1'b0;
               rsp_data     <= 8'h00;
               rsp_flags    <= 8'h00;
               rsp_err      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ula_sequencer.sv
// Self-checking bench for ula_sequencer with a behavioural ULA model and a
// response scoreboard fed at command issue time.
module tb_ula_sequencer;

   localparam int NREG = 4;
   localparam int AW   = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [7:0]    cmd_opcode;
   logic [AW-1:0] cmd_src_a;
   logic [AW-1:0] cmd_src_b;
   logic [AW-1:0] cmd_dst;
   logic [7:0]    cmd_imm;
   logic [7:0]    alu_opcode;
   logic [7:0]    alu_operand1;
   logic [7:0]    alu_operand2;
   logic [7:0]    alu_result;
   logic [7:0]    alu_flags;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [7:0]    rsp_data;
   logic [7:0]    rsp_flags;
   logic          rsp_err;
   logic [7:0]    flags_q;
   logic          busy;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] flags;
      logic       err;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mregs [NREG];
   logic [7:0] mflags;
   int         n_tests = 0;
   int         n_fail  = 0;
   longint     last_accept = 0;
   longint     prev_accept = 0;

   always #5 clk = ~clk;

   // Behavioural ULA: flags[0] zero, flags[1] carry/borrow/overflow, flags[7] sign.
   function automatic logic [15:0] ula_f(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] w;
      logic [7:0]  r;
      logic [7:0]  f;
      w = 16'h0000;
      r = 8'h00;
      f = 8'h00;
      case (op)
         8'h01: begin w = {8'h00, a} + {8'h00, b}; r = w[7:0]; f[1] = w[8]; end
         8'h02: begin w = {8'h00, a} - {8'h00, b}; r = w[7:0]; f[1] = (a < b); end
         8'h03: begin w = {8'h00, a} * {8'h00, b}; r = w[7:0]; f[1] = |w[15:8]; end
         8'h04: begin if (b != 8'h00) r = a / b; end
         8'h05: begin if (b != 8'h00) r = a % b; end
         default: ;
      endcase
      if (op >= 8'h01 && op <= 8'h05) begin
         f[0] = (r == 8'h00);
         f[7] = r[7];
      end
      return {f, r};
   endfunction

   assign {alu_flags, alu_result} = ula_f(alu_opcode, alu_operand1, alu_operand2);

   ula_sequencer #(.NREG(NREG)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_src_a    (cmd_src_a),
      .cmd_src_b    (cmd_src_b),
      .cmd_dst      (cmd_dst),
      .cmd_imm      (cmd_imm),
      .alu_opcode   (alu_opcode),
      .alu_operand1 (alu_operand1),
      .alu_operand2 (alu_operand2),
      .alu_result   (alu_result),
      .alu_flags    (alu_flags),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_flags    (rsp_flags),
      .rsp_err      (rsp_err),
      .flags_q      (flags_q),
      .busy         (busy)
   );

   task automatic model_clear();
      for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
      mflags = 8'h00;
      exp_q.delete();
   endtask

   // Issue one command, check the ULA drive in EXEC, and push the expected response.
   task automatic send(input logic [7:0] op, input int a, input int b, input int d, input logic [7:0] imm);
      int         n;
      exp_t       e;
      logic [7:0] va;
      logic [7:0] vb;
      logic [15:0] fr;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      n_tests++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cmd_ready_wait got %b want 1", cmd_ready);
      end
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_src_a  = AW'(a);
      cmd_src_b  = AW'(b);
      cmd_dst    = AW'(d);
      cmd_imm    = imm;
      @(posedge clk);
      prev_accept = last_accept;
      last_accept = $time;
      #1;
      cmd_valid = 1'b0;
      va = mregs[a];
      vb = mregs[b];
      n_tests++;
      if (alu_opcode !== op || alu_operand1 !== va || alu_operand2 !== vb) begin
         n_fail++;
         $display("FAIL exec_drive got op=%h a=%h b=%h want op=%h a=%h b=%h",
                  alu_opcode, alu_operand1, alu_operand2, op, va, vb);
      end
      e = '0;
      if (op == 8'h10) begin
         e.data   = imm;
         mregs[d] = imm;
      end else if (op >= 8'h01 && op <= 8'h05) begin
         if ((op == 8'h04 || op == 8'h05) && vb == 8'h00) begin
            e.err = 1'b1;
         end else begin
            fr       = ula_f(op, va, vb);
            e.data   = fr[7:0];
            e.flags  = fr[15:8];
            mregs[d] = fr[7:0];
            mflags   = fr[15:8];
         end
      end else begin
         e.err = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   // Wait for the response and compare it against the scoreboard head.
   task automatic check_rsp(input string name);
      int   n;
      exp_t e;
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(posedge clk); #1; n++;
      end
      n_tests++;
      if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s rsp_timeout got valid=%b queued=%0d want valid=1", name, rsp_valid, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         n_tests++;
         if (rsp_data !== e.data || rsp_flags !== e.flags || rsp_err !== e.err) begin
            n_fail++;
            $display("FAIL %s rsp got d=%h f=%h e=%b want d=%h f=%h e=%b",
                     name, rsp_data, rsp_flags, rsp_err, e.data, e.flags, e.err);
         end
         n_tests++;
         if (n !== 1 || flags_q !== mflags || alu_opcode !== 8'h00 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s resp_state got lat=%0d flags_q=%h aluop=%h rdy=%b want lat=1 flags_q=%h aluop=00 rdy=0",
                     name, n, flags_q, alu_opcode, cmd_ready, mflags);
         end
      end
   endtask

   // Complete the response handshake and check return to IDLE.
   task automatic finish_rsp(input string name);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle_return got rdy=%b busy=%b valid=%b want 1 0 0", name, cmd_ready, busy, rsp_valid);
      end
   endtask

   task automatic run(input logic [7:0] op, input int a, input int b, input int d, input logic [7:0] imm, input string name);
      send(op, a, b, d, imm);
      check_rsp(name);
      finish_rsp(name);
   endtask

   task automatic test_reset();
      n_tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
          rsp_data !== 8'h00 || rsp_flags !== 8'h00 || flags_q !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_ctrl got rdy=%b busy=%b v=%b e=%b d=%h f=%h fq=%h want 1 0 0 0 00 00 00",
                  cmd_ready, busy, rsp_valid, rsp_err, rsp_data, rsp_flags, flags_q);
      end
      n_tests++;
      if (alu_opcode !== 8'h00 || alu_operand1 !== 8'h00 || alu_operand2 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_alu got %h %h %h want 00 00 00", alu_opcode, alu_operand1, alu_operand2);
      end
   endtask

   task automatic test_loadi();
      run(8'h10, 0, 0, 0, 8'h07, "loadi_r0");
      run(8'h10, 0, 0, 1, 8'h03, "loadi_r1");
      n_tests++;
      if (flags_q !== 8'h00) begin
         n_fail++;
         $display("FAIL loadi_flags got %h want 00", flags_q);
      end
   endtask

   // ADD with a stalled consumer, then SUB to zero.
   task automatic test_stall_and_arith();
      logic [7:0] d0, f0;
      rsp_ready = 1'b0;
      send(8'h01, 0, 1, 2, 8'h00);
      check_rsp("add_stall");
      d0 = exp_q.size() == 0 ? mregs[2] : 8'h00;
      f0 = mflags;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         n_tests++;
         if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_flags !== f0 || rsp_err !== 1'b0 ||
             cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold got v=%b d=%h f=%h e=%b rdy=%b busy=%b want 1 %h %h 0 0 1",
                     rsp_valid, rsp_data, rsp_flags, rsp_err, cmd_ready, busy, d0, f0);
         end
      end
      finish_rsp("add_stall");
      run(8'h02, 1, 1, 3, 8'h00, "sub_zero");
      n_tests++;
      if (flags_q[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_zero_flag got %b want 1", flags_q[0]);
      end
   endtask

   task automatic test_errors();
      run(8'h04, 0, 3, 0, 8'h00, "div_by_zero");
      run(8'h07, 0, 1, 0, 8'h55, "bad_opcode");
      run(8'h05, 2, 3, 1, 8'h00, "mod_by_zero");
      // r0 must still hold 7: r0 + r3(0)
      run(8'h01, 0, 3, 2, 8'h00, "r0_intact");
   endtask

   task automatic test_back_to_back();
      run(8'h10, 0, 0, 2, 8'hF0, "b2b_loadi_a");
      run(8'h10, 0, 0, 3, 8'h05, "b2b_loadi_b");
      n_tests++;
      if (last_accept - prev_accept !== 64'd30) begin
         n_fail++;
         $display("FAIL b2b_throughput got %0d want 30", last_accept - prev_accept);
      end
      run(8'h03, 2, 3, 1, 8'h00, "b2b_mul");
      run(8'h04, 2, 3, 0, 8'h00, "b2b_div");
      run(8'h05, 2, 3, 3, 8'h00, "b2b_mod_dst_src");
      run(8'h02, 3, 2, 3, 8'h00, "b2b_sub_borrow");
      run(8'h01, 1, 1, 1, 8'h00, "b2b_add_self");
   endtask

   task automatic test_reset_abort();
      run(8'h10, 0, 0, 1, 8'h09, "abort_prep");
      send(8'h03, 0, 1, 0, 8'h00);
      rst = 1'b1;
      #1;
      n_tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || flags_q !== 8'h00 ||
          alu_opcode !== 8'h00 || alu_operand1 !== 8'h00 || alu_operand2 !== 8'h00) begin
         n_fail++;
         $display("FAIL abort_async got rdy=%b busy=%b v=%b fq=%h op=%h want 1 0 0 00 00",
                  cmd_ready, busy, rsp_valid, flags_q, alu_opcode);
      end
      model_clear();
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_tests++;
         if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_rsp got %b want 0", rsp_valid);
         end
      end
      run(8'h01, 0, 1, 2, 8'h00, "abort_r0_r1_zero");
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_opcode = 8'h00;
      cmd_src_a  = '0;
      cmd_src_b  = '0;
      cmd_dst    = '0;
      cmd_imm    = 8'h00;
      rsp_ready  = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_loadi();
      test_stall_and_arith();
      test_errors();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
